// File: rtl/serial_cmd_pkg.sv
// serial_cmd_pkg
//   Shared definitions for the serial command master: opcode values of the
//   board command processor, the master FSM state encoding, size limits and
//   small clamp helpers used when a command is accepted.
package serial_cmd_pkg;

    // Command processor opcodes
    localparam logic [7:0] OP_VERSION      = 8'd0;
    localparam logic [7:0] OP_DEADTICKS    = 8'd1;
    localparam logic [7:0] OP_FIRINGTICKS  = 8'd2;
    localparam logic [7:0] OP_TOGGLE_OUT   = 8'd3;
    localparam logic [7:0] OP_TOGGLE_CLK   = 8'd4;
    localparam logic [7:0] OP_SET_PHASE    = 8'd5;
    localparam logic [7:0] OP_MASK1        = 8'd6;
    localparam logic [7:0] OP_MASK2        = 8'd7;
    localparam logic [7:0] OP_PASSTHRU     = 8'd8;
    localparam logic [7:0] OP_HISTO        = 8'd10;
    localparam logic [7:0] OP_VETO_LAST    = 8'd11;
    localparam logic [7:0] OP_RESET_PLL    = 8'd13;
    localparam logic [7:0] OP_VETO_CYCLES  = 8'd14;
    localparam logic [7:0] OP_CLK_AS_INPUT = 8'd15;

    localparam int MAX_ARGS         = 10;
    localparam int HISTO_RESP_BYTES = 288;
    localparam int MAX_RESP         = HISTO_RESP_BYTES;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX_WAIT = 3'd1,
        S_TX_GAP  = 3'd2,
        S_RECV    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic logic [3:0] clamp_nargs(input logic [3:0] n);
        return (n > 4'(MAX_ARGS)) ? 4'(MAX_ARGS) : n;
    endfunction

    function automatic logic [8:0] clamp_nresp(input logic [8:0] n);
        return (n > 9'(MAX_RESP)) ? 9'(MAX_RESP) : n;
    endfunction

endpackage

// File: rtl/serial_cmd_master_if.sv
// serial_cmd_master_if
//   Bundles the command request, UART TX/RX and response/status signals of
//   the serial command master.
//   Handshake: a command transfers on a clock edge where cmd_valid and
//   cmd_ready are both high; cmd_* must be stable while cmd_valid is high.
//   txStart, rxReady, resp_valid, resp_word_valid, done and rx_drop are
//   single-cycle strobes with no back-pressure; txBusy is a level that holds
//   off the next txStart.
//   Modports: master = the command master, slave = its environment.
interface serial_cmd_master_if import serial_cmd_pkg::*; ();
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [7:0]              cmd_opcode;
    logic [3:0]              cmd_nargs;
    logic [8*MAX_ARGS-1:0]   cmd_args;
    logic [8:0]              cmd_nresp;
    logic                    txBusy;
    logic                    txStart;
    logic [7:0]              txData;
    logic                    rxReady;
    logic [7:0]              rxData;
    logic                    resp_valid;
    logic [7:0]              resp_data;
    logic [8:0]              resp_index;
    logic                    resp_word_valid;
    logic [31:0]             resp_word;
    logic                    done;
    logic                    timeout;
    logic [8:0]              resp_count;
    logic                    rx_drop;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
        input  txBusy, rxReady, rxData,
        output cmd_ready, txStart, txData,
        output resp_valid, resp_data, resp_index, resp_word_valid, resp_word,
        output done, timeout, resp_count, rx_drop
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
        output txBusy, rxReady, rxData,
        input  cmd_ready, txStart, txData,
        input  resp_valid, resp_data, resp_index, resp_word_valid, resp_word,
        input  done, timeout, resp_count, rx_drop
    );
endinterface

// File: rtl/serial_cmd_master_resp_word_packer.sv
// resp_word_packer
//   Assembles response bytes into little-endian 32-bit words.
//   Ports: clk, reset_n (async active-low); byte_valid/byte_lane/byte_data
//   describe one response byte (lane = index mod 4); last_byte marks the final
//   byte of the response; word_valid/word present the assembled word in the
//   same cycle as the byte that completes it.
module resp_word_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [1:0]  byte_lane,
    input  logic [7:0]  byte_data,
    input  logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [31:0] word_q;
    logic [31:0] word_d;
    logic [31:0] merged;

    always_comb begin
        merged = word_q;
        // Lane 0 starts a fresh word, so a short final word has zero upper bytes.
        if (byte_lane == 2'd0) begin
            merged = {24'h0, byte_data};
        end else begin
            merged[{byte_lane, 3'b000} +: 8] = byte_data;
        end
        word_d = byte_valid ? merged : word_q;
    end

    assign word       = word_d;
    assign word_valid = byte_valid && ((byte_lane == 2'd3) || last_byte);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= 32'h0;
        end else begin
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/serial_cmd_master.sv
// serial_cmd_master
//   Initiator of the byte-serial command protocol. Accepts one command,
//   sends opcode then arguments through a UART TX, collects the expected
//   response bytes from a UART RX and streams them as bytes and words.
//   Ports: clk, reset_n (async active-low), bus (serial_cmd_master_if.master:
//   command handshake, UART TX/RX, response stream, status), state_dbg
//   (current FSM state for observation).
//   TIMEOUT_CYCLES must be at least 2.
module serial_cmd_master import serial_cmd_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                reset_n,
    serial_cmd_master_if.master bus,
    output state_t              state_dbg
);
    localparam logic [31:0] TIMER_TC = 32'(TIMEOUT_CYCLES - 1);
    localparam int          FRAME_W  = 8 * (MAX_ARGS + 1);

    state_t               state_q, state_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;   // {args, opcode}: byte k is sent k-th
    logic [3:0]           nargs_q, nargs_d;
    logic [8:0]           nresp_q, nresp_d;
    logic [31:0]          timer_q, timer_d;
    logic [8:0]           count_q, count_d;
    logic                 timeout_q, timeout_d;
    logic [8:0]           resp_count_q, resp_count_d;

    logic                 tx_start;
    logic                 resp_valid;
    logic                 last_byte;
    logic                 done;
    logic [7:0]           cur_byte;

    assign cur_byte = frame_q[{ptr_q, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        frame_d      = frame_q;
        nargs_d      = nargs_q;
        nresp_d      = nresp_q;
        timer_d      = timer_q;
        count_d      = count_q;
        timeout_d    = timeout_q;
        resp_count_d = resp_count_q;
        tx_start     = 1'b0;
        resp_valid   = 1'b0;
        last_byte    = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    frame_d      = {bus.cmd_args, bus.cmd_opcode};
                    nargs_d      = clamp_nargs(bus.cmd_nargs);
                    nresp_d      = clamp_nresp(bus.cmd_nresp);
                    timeout_d    = 1'b0;
                    resp_count_d = 9'd0;
                    count_d      = 9'd0;
                    ptr_d        = 4'd0;
                    state_d      = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (!bus.txBusy) begin
                    tx_start = 1'b1;
                    state_d  = S_TX_GAP;
                end
            end
            S_TX_GAP: begin
                // Pointer value p has sent p+1 bytes; nargs+1 bytes in total.
                if (ptr_q != nargs_q) begin
                    ptr_d   = ptr_q + 4'd1;
                    state_d = S_TX_WAIT;
                end else if (nresp_q == 9'd0) begin
                    resp_count_d = count_q;
                    state_d      = S_DONE;
                end else begin
                    timer_d = 32'd0;
                    count_d = 9'd0;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (bus.rxReady) begin
                    // A byte always beats a simultaneous timer expiry.
                    resp_valid = 1'b1;
                    count_d    = count_q + 9'd1;
                    timer_d    = 32'd0;
                    last_byte  = (count_d == nresp_q);
                    if (last_byte) begin
                        resp_count_d = count_d;
                        state_d      = S_DONE;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                    if (timer_d == TIMER_TC) begin
                        timeout_d    = 1'b1;
                        resp_count_d = count_q;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= 4'd0;
            frame_q      <= '0;
            nargs_q      <= 4'd0;
            nresp_q      <= 9'd0;
            timer_q      <= 32'd0;
            count_q      <= 9'd0;
            timeout_q    <= 1'b0;
            resp_count_q <= 9'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            frame_q      <= frame_d;
            nargs_q      <= nargs_d;
            nresp_q      <= nresp_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            timeout_q    <= timeout_d;
            resp_count_q <= resp_count_d;
        end
    end

    resp_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_valid (resp_valid),
        .byte_lane  (count_q[1:0]),
        .byte_data  (bus.rxData),
        .last_byte  (last_byte),
        .word_valid (bus.resp_word_valid),
        .word       (bus.resp_word)
    );

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.txStart    = tx_start;
    assign bus.txData     = tx_start ? cur_byte : 8'h00;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_valid ? bus.rxData : 8'h00;
    assign bus.resp_index = resp_valid ? count_q : 9'd0;
    assign bus.done       = done;
    assign bus.timeout    = timeout_q;
    assign bus.resp_count = resp_count_q;
    assign bus.rx_drop    = bus.rxReady && (state_q != S_RECV);
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_serial_cmd_master.sv
module tb_serial_cmd_master;
    import serial_cmd_pkg::*;

    localparam int TO_CYC = 100;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   reset_n = 1'b1;
    state_t state_dbg;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_cmd_master_if bus();

    serial_cmd_master #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0]  exp_q[$];     // expected transmitted bytes
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    logic [7:0]  resp_q[$];
    logic [8:0]  idx_q[$];
    logic [31:0] word_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_timeout = 1'b0;
    logic [8:0]  done_rcount = 9'd0;
    int          drop_cnt = 0;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.txStart) begin
            tx_q.push_back(bus.txData);
            tx_cyc_q.push_back(cyc);
        end
        if (bus.resp_valid) begin
            resp_q.push_back(bus.resp_data);
            idx_q.push_back(bus.resp_index);
        end
        if (bus.resp_word_valid) word_q.push_back(bus.resp_word);
        if (bus.done) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            done_timeout <= bus.timeout;
            done_rcount  <= bus.resp_count;
        end
        if (bus.rx_drop) drop_cnt <= drop_cnt + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete();
        tx_q.delete();
        tx_cyc_q.delete();
        resp_q.delete();
        idx_q.delete();
        word_q.delete();
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [3:0] na,
                            input logic [79:0] args, input logic [8:0] nr,
                            output int acc);
        int n = 0;
        while (!bus.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: got %b expected 1", bus.cmd_ready);
        end
        bus.cmd_opcode = op;
        bus.cmd_nargs  = na;
        bus.cmd_args   = args;
        bus.cmd_nresp  = nr;
        bus.cmd_valid  = 1'b1;
        acc = cyc;
        tick();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int budget);
        int n = 0;
        while (state_dbg != s && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (state_dbg !== s) begin
            n_fail++;
            $display("FAIL wait_state: got %0d expected %0d", state_dbg, s);
        end
    endtask

    task automatic wait_done(input int start, input int budget);
        int n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (done_cnt == start) begin
            n_fail++;
            $display("FAIL wait_done: got no done within %0d cycles expected one", budget);
        end
        tick();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.rxReady = 1'b1;
        bus.rxData  = b;
        tick();
        bus.rxReady = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_cmp += 9;
        if (bus.cmd_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 1", bus.cmd_ready); end
        if (bus.txStart !== 1'b0)       begin n_fail++; $display("FAIL rst_txStart: got %b expected 0", bus.txStart); end
        if (bus.txData !== 8'h00)       begin n_fail++; $display("FAIL rst_txData: got %h expected 00", bus.txData); end
        if (bus.resp_word !== 32'h0)    begin n_fail++; $display("FAIL rst_resp_word: got %h expected 0", bus.resp_word); end
        if (bus.resp_index !== 9'd0)    begin n_fail++; $display("FAIL rst_resp_index: got %0d expected 0", bus.resp_index); end
        if (bus.timeout !== 1'b0)       begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", bus.timeout); end
        if (bus.resp_count !== 9'd0)    begin n_fail++; $display("FAIL rst_resp_count: got %0d expected 0", bus.resp_count); end
        if (bus.done !== 1'b0)          begin n_fail++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        if (state_dbg !== S_IDLE)       begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_version();
        int acc;
        int start;
        clear_logs();
        exp_q.push_back(8'h00);
        start = done_cnt;
        send_cmd(OP_VERSION, 4'd0, 80'h0, 9'd1, acc);
        wait_state(S_RECV, 20);
        rx_byte(8'h15);
        wait_done(start, 20);
        n_cmp += 10;
        if (tx_q.size() != 1)          begin n_fail++; $display("FAIL ver_tx_count: got %0d expected 1", tx_q.size()); end
        if (tx_q[0] !== exp_q[0])      begin n_fail++; $display("FAIL ver_tx_byte: got %h expected %h", tx_q[0], exp_q[0]); end
        if (tx_cyc_q[0] != acc + 1)    begin n_fail++; $display("FAIL ver_tx_latency: got %0d expected %0d", tx_cyc_q[0], acc + 1); end
        if (resp_q.size() != 1)        begin n_fail++; $display("FAIL ver_resp_count: got %0d expected 1", resp_q.size()); end
        if (resp_q[0] !== 8'h15)       begin n_fail++; $display("FAIL ver_resp_data: got %h expected 15", resp_q[0]); end
        if (idx_q[0] !== 9'd0)         begin n_fail++; $display("FAIL ver_resp_index: got %0d expected 0", idx_q[0]); end
        if (word_q.size() != 1)        begin n_fail++; $display("FAIL ver_word_count: got %0d expected 1", word_q.size()); end
        if (word_q[0] !== 32'h15)      begin n_fail++; $display("FAIL ver_word: got %h expected 00000015", word_q[0]); end
        if (done_timeout !== 1'b0)     begin n_fail++; $display("FAIL ver_timeout: got %b expected 0", done_timeout); end
        if (done_rcount !== 9'd1)      begin n_fail++; $display("FAIL ver_rcount: got %0d expected 1", done_rcount); end
    endtask

    task automatic test_deadticks();
        int acc;
        int start;
        clear_logs();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h0A);
        start = done_cnt;
        send_cmd(OP_DEADTICKS, 4'd1, {72'h0, 8'h0A}, 9'd0, acc);
        wait_done(start, 20);
        n_cmp += 6;
        if (tx_q.size() != 2)          begin n_fail++; $display("FAIL dt_tx_count: got %0d expected 2", tx_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (tx_q[i] !== exp_q[i])  begin n_fail++; $display("FAIL dt_tx_byte%0d: got %h expected %h", i, tx_q[i], exp_q[i]); end
        end
        if (tx_cyc_q[1] != acc + 3)    begin n_fail++; $display("FAIL dt_tx2_cycle: got %0d expected %0d", tx_cyc_q[1], acc + 3); end
        if (done_cyc != acc + 5)       begin n_fail++; $display("FAIL dt_done_cycle: got %0d expected %0d", done_cyc, acc + 5); end
        if (resp_q.size() != 0)        begin n_fail++; $display("FAIL dt_no_resp: got %0d expected 0", resp_q.size()); end
        if (done_rcount !== 9'd0)      begin n_fail++; $display("FAIL dt_rcount: got %0d expected 0", done_rcount); end
        if (done_timeout !== 1'b0)     begin n_fail++; $display("FAIL dt_timeout: got %b expected 0", done_timeout); end
    endtask

    task automatic test_histogram();
        int acc;
        int start;
        logic [7:0]  hb[HISTO_RESP_BYTES];
        logic [31:0] w;
        hb[0] = 8'h78; hb[1] = 8'h56; hb[2] = 8'h34; hb[3] = 8'h12;
        for (int i = 4; i < HISTO_RESP_BYTES; i++) hb[i] = 8'((i * 7) + 3);
        clear_logs();
        start = done_cnt;
        send_cmd(OP_HISTO, 4'd0, 80'h0, 9'd288, acc);
        wait_state(S_RECV, 20);
        for (int i = 0; i < HISTO_RESP_BYTES; i++) begin
            rx_byte(hb[i]);
            if (i % 3 == 2) tick();
        end
        wait_done(start, 20);
        n_cmp += 5;
        if (resp_q.size() != 288)      begin n_fail++; $display("FAIL hist_resp_count: got %0d expected 288", resp_q.size()); end
        if (word_q.size() != 72)       begin n_fail++; $display("FAIL hist_word_count: got %0d expected 72", word_q.size()); end
        if (word_q[0] !== 32'h12345678) begin n_fail++; $display("FAIL hist_word0: got %h expected 12345678", word_q[0]); end
        if (done_rcount !== 9'd288)    begin n_fail++; $display("FAIL hist_rcount: got %0d expected 288", done_rcount); end
        if (done_timeout !== 1'b0)     begin n_fail++; $display("FAIL hist_timeout: got %b expected 0", done_timeout); end
        for (int i = 0; i < resp_q.size() && i < HISTO_RESP_BYTES; i++) begin
            n_cmp += 2;
            if (resp_q[i] !== hb[i])   begin n_fail++; $display("FAIL hist_byte%0d: got %h expected %h", i, resp_q[i], hb[i]); end
            if (idx_q[i] !== 9'(i))    begin n_fail++; $display("FAIL hist_index%0d: got %0d expected %0d", i, idx_q[i], i); end
        end
        for (int k = 0; k < word_q.size() && k < 72; k++) begin
            w = {hb[4*k+3], hb[4*k+2], hb[4*k+1], hb[4*k]};
            n_cmp++;
            if (word_q[k] !== w)       begin n_fail++; $display("FAIL hist_word%0d: got %h expected %h", k, word_q[k], w); end
        end
    endtask

    task automatic test_timeout();
        int acc;
        int start;
        int last_cyc;
        clear_logs();
        start = done_cnt;
        send_cmd(OP_MASK1, 4'd0, 80'h0, 9'd4, acc);
        wait_state(S_RECV, 20);
        rx_byte(8'hAA);
        tick();
        last_cyc = cyc;
        rx_byte(8'hBB);
        wait_done(start, 3 * TO_CYC);
        n_cmp += 5;
        if (done_cyc - last_cyc != TO_CYC) begin n_fail++; $display("FAIL to_done_delay: got %0d expected %0d", done_cyc - last_cyc, TO_CYC); end
        if (done_timeout !== 1'b1)     begin n_fail++; $display("FAIL to_timeout: got %b expected 1", done_timeout); end
        if (done_rcount !== 9'd2)      begin n_fail++; $display("FAIL to_rcount: got %0d expected 2", done_rcount); end
        if (word_q.size() != 0)        begin n_fail++; $display("FAIL to_no_word: got %0d expected 0", word_q.size()); end
        if (resp_q.size() != 2)        begin n_fail++; $display("FAIL to_resp_count: got %0d expected 2", resp_q.size()); end
    endtask

    task automatic test_backpressure();
        int acc;
        int start;
        int drop0;
        int rel;
        clear_logs();
        start = done_cnt;
        drop0 = drop_cnt;
        bus.txBusy = 1'b1;
        send_cmd(OP_TOGGLE_OUT, 4'd0, 80'h0, 9'd0, acc);
        n_cmp += 2;
        if (bus.timeout !== 1'b0)      begin n_fail++; $display("FAIL bp_timeout_cleared: got %b expected 0", bus.timeout); end
        if (bus.resp_count !== 9'd0)   begin n_fail++; $display("FAIL bp_rcount_cleared: got %0d expected 0", bus.resp_count); end
        for (int i = 0; i < 50; i++) begin
            if (i == 10 || i == 30) rx_byte(8'hC3);
            else tick();
        end
        n_cmp++;
        if (tx_q.size() != 0)          begin n_fail++; $display("FAIL bp_held: got %0d starts expected 0", tx_q.size()); end
        bus.txBusy = 1'b0;
        rel = cyc;
        wait_done(start, 20);
        n_cmp += 5;
        if (tx_q.size() != 1)          begin n_fail++; $display("FAIL bp_tx_count: got %0d expected 1", tx_q.size()); end
        if (tx_q[0] !== OP_TOGGLE_OUT) begin n_fail++; $display("FAIL bp_tx_byte: got %h expected 03", tx_q[0]); end
        if (tx_cyc_q[0] != rel)        begin n_fail++; $display("FAIL bp_tx_cycle: got %0d expected %0d", tx_cyc_q[0], rel); end
        if (drop_cnt - drop0 != 2)     begin n_fail++; $display("FAIL bp_rx_drop: got %0d expected 2", drop_cnt - drop0); end
        if (resp_q.size() != 0)        begin n_fail++; $display("FAIL bp_no_resp: got %0d expected 0", resp_q.size()); end
    endtask

    task automatic test_nargs_clamp();
        int acc;
        int start;
        logic [79:0] args;
        clear_logs();
        exp_q.push_back(OP_SET_PHASE);
        for (int k = 0; k < 10; k++) begin
            args[8*k +: 8] = 8'(8'h10 + k);
            exp_q.push_back(8'(8'h10 + k));
        end
        start = done_cnt;
        send_cmd(OP_SET_PHASE, 4'd15, args, 9'd0, acc);
        wait_done(start, 60);
        n_cmp++;
        if (tx_q.size() != 11)         begin n_fail++; $display("FAIL clamp_tx_count: got %0d expected 11", tx_q.size()); end
        for (int i = 0; i < 11 && i < tx_q.size(); i++) begin
            n_cmp++;
            if (tx_q[i] !== exp_q[i])  begin n_fail++; $display("FAIL clamp_tx_byte%0d: got %h expected %h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_send();
        int acc;
        int start;
        clear_logs();
        start = done_cnt;
        send_cmd(OP_SET_PHASE, 4'd1, {72'h0, 8'h33}, 9'd0, acc);
        tick();
        tick();
        n_cmp += 2;
        if (bus.txStart !== 1'b1)      begin n_fail++; $display("FAIL rm_arg_start: got %b expected 1", bus.txStart); end
        if (bus.txData !== 8'h33)      begin n_fail++; $display("FAIL rm_arg_data: got %h expected 33", bus.txData); end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.txStart !== 1'b0)      begin n_fail++; $display("FAIL rm_async_drop: got %b expected 0", bus.txStart); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp += 2;
        if (bus.cmd_ready !== 1'b1)    begin n_fail++; $display("FAIL rm_cmd_ready: got %b expected 1", bus.cmd_ready); end
        if (state_dbg !== S_IDLE)      begin n_fail++; $display("FAIL rm_state: got %0d expected 0", state_dbg); end
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (done_cnt != start)         begin n_fail++; $display("FAIL rm_no_done: got %0d dones expected 0", done_cnt - start); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = 8'h00;
        bus.cmd_nargs  = 4'd0;
        bus.cmd_args   = '0;
        bus.cmd_nresp  = 9'd0;
        bus.txBusy     = 1'b0;
        bus.rxReady    = 1'b0;
        bus.rxData     = 8'h00;

        test_reset();
        test_version();
        test_deadticks();
        test_histogram();
        test_timeout();
        test_backpressure();
        test_nargs_clamp();
        test_reset_mid_send();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
